serial_add_sub: RTL and testbench
=================================

Name: serial_add_sub

Overview:
Parametrised bit-serial two's-complement adder/subtractor with a start/done handshake. It replaces the fixed 3-bit ripple adder/subtractor wherever area matters more than latency. A single full-adder cell processes one bit per clock, LSB first, and reports carry, signed overflow and zero flags. It sits beside the ALU datapath as a multi-cycle arithmetic unit.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..64.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
start  input  1  request; accepted only when ready=1
op  input  1  0 = add (a+b), 1 = subtract (a-b)
a  input  WIDTH  operand A, sampled on the accepted start
b  input  WIDTH  operand B, sampled on the accepted start
ready  output  1  high in IDLE
done  output  1  one-cycle pulse when result/flags become valid
result  output  WIDTH  sum or difference, modulo 2^WIDTH
carry_out  output  1  adder carry from the MSB (for subtract: 1 = no borrow, a>=b unsigned)
overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB
zero  output  1  result == 0

Behaviour:
- Clock/reset: one clock, clk; reset is synchronous and active-low, rst_n. Reset is sampled only on a rising edge of clk.
- Reset values:
  - state IDLE; ready=1, done=0.
  - result=0, carry_out=0, overflow=0, zero=0.
  - Internal shift registers, carry flop and bit counter all cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - On an edge with start=1, latch a into sh_a.
  - Latch b (op=0) or ~b (op=1) into sh_b.
  - Set carry flop to op (the +1 for two's-complement subtract), clear the counter and go to RUN.
  - start=0 keeps the block in IDLE.
- RUN: each edge performs these steps:
  - The full-adder cell combines sh_a[0], sh_b[0] and the carry flop.
  - The sum bit shifts into the MSB of the working result register, which shifts right.
  - sh_a and sh_b shift right and the carry flop takes the cell carry.
  - The counter increments.
  - On the edge processing bit WIDTH-1, latch the carry into the MSB as well, then go to DONE.
- Entering DONE, the output registers load together:
  - result takes the completed working register.
  - carry_out takes the final cell carry.
  - overflow = carry-in of the MSB XOR final carry.
  - zero = (result==0).
- DONE: done=1 for exactly that cycle, ready=0; the next edge returns to IDLE.
- Latency: start accepted on edge E means done is high in the cycle following edge E+WIDTH, and ready is high again after edge E+WIDTH+1. Throughput is one operation per WIDTH+2 cycles.
- Output holding:
  - result and all flags hold their last completed values until the next DONE.
  - They do not change during RUN; partial results are never visible.
- start while ready=0 (RUN or DONE) is ignored, with no queuing.
- a, b and op may change freely after acceptance.
- Widths: all arithmetic is modulo 2^WIDTH; no sign-extension or saturation.
- Reset mid-operation: rst_n=0 on any edge aborts the operation and applies the reset values above. No done pulse is produced for the aborted operation.
- start asserted in the same cycle as rst_n=0: reset wins and start is dropped.

Decomposition:
- Shared package arith_pkg contains:
  - state enum {IDLE, RUN, DONE};
  - op constants OP_ADD=1'b0 and OP_SUB=1'b1;
  - the counter width function clog2(WIDTH).
- One natural sub-module: full_adder_cell, a combinational (x, y, cin) -> (s, cout) cell instantiated once.
- Sequencing, shift registers and flags live in serial_add_sub.

Test Plan:
- WIDTH=8, add 100+27 -> result=0x7F, carry_out=0, overflow=0, zero=0. done pulses exactly 8 cycles after the start edge, then ready returns.
- WIDTH=8, sub 2-2 -> result=0x00, carry_out=1, zero=1, overflow=0. Also add 255+1 -> result=0x00, carry_out=1, zero=1.
- WIDTH=8, overflow cases:
  - sub 1-5 -> result=0xFC, carry_out=0 (borrow), overflow=0;
  - add 127+1 -> result=0x80, overflow=1;
  - sub 0x80-1 -> result=0x7F, overflow=1.
- WIDTH=3, sub 3-6 -> result=3'b101, carry_out=0. Also sub 1-5 -> result=3'b100. done must occur 3 cycles after the start edge.
- Mid-run traffic: start pulses while in RUN and in DONE are ignored, giving a single done pulse. Changing a/b during RUN does not alter the result. The previous result stays stable until the new done.
- Reset mid-operation: rst_n=0 on RUN cycle 4 -> next cycle ready=1, result=0, all flags 0, no done pulse. A new start after release completes normally.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared types and helpers for the multi-cycle arithmetic units beside the ALU.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Bits needed to count 0..n-1; never less than 1.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/serial_add_sub_if.sv
// Request/response bundle of the bit-serial adder/subtractor.
interface serial_add_sub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;
  logic             zero;

  modport master (
    output start, op, a, b,
    input  ready, done, result, carry_out, overflow, zero
  );

  modport slave (
    input  start, op, a, b,
    output ready, done, result, carry_out, overflow, zero
  );
endinterface

// File: rtl/full_adder_cell.sv
// One-bit full adder: the only arithmetic cell of the serial unit.
// Latency: combinational.
// Backpressure: none.
module full_adder_cell (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = x ^ y ^ cin;
  assign cout = (x & y) | (cin & (x ^ y));
endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial two's-complement add/sub, LSB first, one bit per clock.
// Latency: done in the cycle after edge start+WIDTH; ready again one edge later.
// Backpressure: start is ignored (not queued) whenever ready is low.
module serial_add_sub
  import arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  serial_add_sub_if.slave  bus
);

  localparam int             CW   = clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sh_a, sh_b, sh_r;
  logic [WIDTH-1:0] sum_word;
  logic [CW-1:0]    cnt;
  logic             cy, s, co, last;

  logic [WIDTH-1:0] result_q;
  logic             carry_q, ovf_q, zero_q;

  full_adder_cell u_fa (
    .x    (sh_a[0]),
    .y    (sh_b[0]),
    .cin  (cy),
    .s    (s),
    .cout (co)
  );

  assign last     = (cnt == LAST);
  // Working register with this cycle's sum bit already shifted in at the MSB.
  assign sum_word = {s, {(WIDTH-1){1'b0}}} | (sh_r >> 1);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:                   state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_a     <= '0;
      sh_b     <= '0;
      sh_r     <= '0;
      cy       <= 1'b0;
      cnt      <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            sh_a <= bus.a;
            // Subtract as a + ~b + 1: the +1 rides in on the initial carry.
            sh_b <= (bus.op == OP_SUB) ? ~bus.b : bus.b;
            cy   <= bus.op;
            cnt  <= '0;
          end
        end
        RUN: begin
          sh_a <= sh_a >> 1;
          sh_b <= sh_b >> 1;
          sh_r <= sum_word;
          cy   <= co;
          cnt  <= cnt + 1'b1;
          if (last) begin
            result_q <= sum_word;
            carry_q  <= co;
            ovf_q    <= cy ^ co;
            zero_q   <= ~|sum_word;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ready     = (state == IDLE);
  assign bus.done      = (state == DONE);
  assign bus.result    = result_q;
  assign bus.carry_out = carry_q;
  assign bus.overflow  = ovf_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Scoreboard bench: WIDTH=8 and WIDTH=3 instances checked against an integer reference model.
module tb_serial_add_sub;
  import arith_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rst_q = 1'b0;
  int   cyc   = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst_n;
  end

  serial_add_sub_if #(.WIDTH(8)) if8 ();
  serial_add_sub_if #(.WIDTH(3)) if3 ();

  serial_add_sub #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
  serial_add_sub #(.WIDTH(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

  typedef struct packed {
    logic [7:0] res;
    logic       c;
    logic       v;
    logic       z;
    int         t0;
  } exp_t;

  exp_t q8[$];
  exp_t q3[$];
  exp_t h8 = '0;
  exp_t h3 = '0;
  exp_t e8, e3;

  // Reference: plain unsigned/signed integer arithmetic on w-bit operands.
  function automatic exp_t model(int w, logic op, logic [7:0] a, logic [7:0] b, int t0);
    exp_t   e;
    longint m, half, ua, ub, sa, sb, sr;
    m    = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ua   = longint'(a) & m;
    ub   = longint'(b) & m;
    sa   = (ua >= half) ? ua - (m + 1) : ua;
    sb   = (ub >= half) ? ub - (m + 1) : ub;
    sr   = op ? sa - sb : sa + sb;
    e.res = 8'((op ? ua - ub : ua + ub) & m);
    e.c   = op ? (ua >= ub) : (((ua + ub) >> w) != 0);
    e.v   = (sr >= half) || (sr < -half);
    e.z   = (e.res == 8'd0);
    e.t0  = t0;
    return e;
  endfunction

  task automatic cmp(string nm, longint got, longint want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", nm, got, want);
    end
  endtask

  task automatic chk_done(string tag, int w, exp_t e, logic [7:0] res, logic c, logic v, logic z);
    cmp({tag, "_result"},   res, e.res);
    cmp({tag, "_carry"},    c,   e.c);
    cmp({tag, "_overflow"}, v,   e.v);
    cmp({tag, "_zero"},     z,   e.z);
    cmp({tag, "_latency"},  cyc - e.t0, w);
  endtask

  always @(negedge clk) begin
    if (!rst_q) begin
      q8.delete();
      q3.delete();
      h8 = '0;
      h3 = '0;
      cmp("rst_ready8", if8.ready, 1);
      cmp("rst_done8",  if8.done, 0);
      cmp("rst_out8",   {if8.result, if8.carry_out, if8.overflow, if8.zero}, 0);
      cmp("rst_ready3", if3.ready, 1);
      cmp("rst_done3",  if3.done, 0);
      cmp("rst_out3",   {if3.result, if3.carry_out, if3.overflow, if3.zero}, 0);
    end else begin
      if (if8.done) begin
        if (q8.size() == 0) cmp("spurious_done8", if8.done, 0);
        else begin
          e8 = q8.pop_front();
          chk_done("w8", 8, e8, if8.result, if8.carry_out, if8.overflow, if8.zero);
          h8 = e8;
        end
      end else
        cmp("hold8", {if8.result, if8.carry_out, if8.overflow, if8.zero},
            {h8.res, h8.c, h8.v, h8.z});
      if (if3.done) begin
        if (q3.size() == 0) cmp("spurious_done3", if3.done, 0);
        else begin
          e3 = q3.pop_front();
          chk_done("w3", 3, e3, {5'd0, if3.result}, if3.carry_out, if3.overflow, if3.zero);
          h3 = e3;
        end
      end else
        cmp("hold3", {if3.result, if3.carry_out, if3.overflow, if3.zero},
            {h3.res[2:0], h3.c, h3.v, h3.z});
    end
  end

  task automatic wait_ready(int d);
    for (int i = 0; i < 60; i++) begin
      if ((d == 0) ? if8.ready : if3.ready) break;
      @(posedge clk); #1;
    end
    cmp((d == 0) ? "ready_wait8" : "ready_wait3", (d == 0) ? if8.ready : if3.ready, 1);
  endtask

  task automatic issue(int d, logic op, logic [7:0] a, logic [7:0] b);
    wait_ready(d);
    if (d == 0) begin
      if8.start = 1'b1; if8.op = op; if8.a = a; if8.b = b;
    end else begin
      if3.start = 1'b1; if3.op = op; if3.a = a[2:0]; if3.b = b[2:0];
    end
    @(posedge clk); #1;
    // Operands are scrambled right after acceptance; the result must not follow them.
    if (d == 0) begin
      q8.push_back(model(8, op, a, b, cyc));
      if8.start = 1'b0; if8.op = 1'($urandom);
      if8.a = 8'($urandom); if8.b = 8'($urandom);
    end else begin
      q3.push_back(model(3, op, a, b, cyc));
      if3.start = 1'b0; if3.op = 1'($urandom);
      if3.a = 3'($urandom); if3.b = 3'($urandom);
    end
  endtask

  initial begin
    if8.start = 1'b0; if8.op = OP_ADD; if8.a = '0; if8.b = '0;
    if3.start = 1'b0; if3.op = OP_ADD; if3.a = '0; if3.b = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    issue(0, OP_ADD, 8'd100,  8'd27);
    issue(0, OP_SUB, 8'd2,    8'd2);
    issue(0, OP_ADD, 8'd255,  8'd1);
    issue(0, OP_SUB, 8'd1,    8'd5);
    issue(0, OP_ADD, 8'd127,  8'd1);
    issue(0, OP_SUB, 8'h80,   8'd1);
    issue(1, OP_SUB, 8'd3,    8'd6);
    issue(1, OP_SUB, 8'd1,    8'd5);
    issue(1, OP_ADD, 8'd3,    8'd1);

    for (int i = 0; i < 40; i++)
      issue(i % 2, 1'($urandom), 8'($urandom), 8'($urandom));

    // Start pulses during RUN and DONE must be dropped.
    issue(0, OP_ADD, 8'd10, 8'd20);
    repeat (2) begin
      if8.start = 1'b1; if8.a = 8'($urandom); if8.b = 8'($urandom);
      @(posedge clk); #1;
    end
    if8.start = 1'b0;
    for (int i = 0; i < 20 && !if8.done; i++) begin
      @(posedge clk); #1;
    end
    cmp("traffic_done_seen", if8.done, 1);
    if8.start = 1'b1;
    @(posedge clk); #1;
    if8.start = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
    end

    // Abort on RUN cycle 4, with start held in the same reset cycle.
    issue(0, OP_SUB, 8'h55, 8'h0F);
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0; if8.start = 1'b1; if3.start = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1; if8.start = 1'b0; if3.start = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
    end
    issue(0, OP_ADD, 8'd100, 8'd27);
    issue(1, OP_SUB, 8'd3,   8'd6);

    for (int i = 0; i < 100 && (q8.size() + q3.size()) != 0; i++) begin
      @(posedge clk); #1;
    end
    cmp("scoreboard_drained", q8.size() + q3.size(), 0);
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
